sync_delay_measure: RTL and testbench
=====================================

Name: sync_delay_measure

Overview:
Measures the latency, in clock cycles, of a delay path such as the RAM-based shift register in the sync_delay tree. The block drives a marker into the path, watches the return end, and reports the cycle count between driving the marker and seeing it come back. It is used in self-test and in benches to confirm that a programmed delay tap gives the expected latency.

Parameters:
DSIZE, 1, width of the stimulus and return data buses.
MAX_DELAY, 64, largest latency that can be measured; it also sets the flush length and the timeout.
CSIZE, $clog2(MAX_DELAY+1), width of the delay count.

Ports:
clk  input  1  single clock; everything changes on its rising edge.
Reset  input  1  asynchronous, active-low reset.
start  input  1  single-cycle request to begin a measurement.
Dout  output  DSIZE  registered stimulus driven into the delay path.
Din_ret  input  DSIZE  return end of the delay path.
busy  output  1  high from the start being accepted until done or timeout.
done  output  1  one-cycle pulse: marker found, delay is valid.
timeout  output  1  one-cycle pulse: no marker seen within MAX_DELAY cycles.
delay  output  CSIZE  measured latency, held until the next accepted start.
delay_valid  output  1  high after done; cleared on the next accepted start or on timeout.

Behaviour:
- Reset values: while Reset is low, all outputs are 0, the state is IDLE and the counters are 0. Reset is asynchronous and can occur in any state.
- MARKER is all-ones of width DSIZE. The idle value on Dout is all-zeros.
- States are IDLE, FLUSH, SEND, WAIT.
- IDLE: Dout=0 and busy=0. When start=1, go to FLUSH, set busy=1, clear delay_valid, and clear the counter.
- start is ignored whenever busy=1, and no state is affected.
- FLUSH: drive Dout=0 for exactly MAX_DELAY cycles so stale data drains out of the path. Then go to SEND.
- SEND: lasts one cycle. Dout=MARKER during this cycle, which is defined as cycle 0. The counter is 0.
- The compare Din_ret==MARKER is evaluated combinationally in SEND and in every WAIT cycle.
- A match in SEND means delay=0 (a direct wire from Dout to Din_ret).
- If SEND does not match, go to WAIT with Dout=0 and the counter at 1.
- WAIT: the counter increments each cycle. Only the first match counts.
- On a match in cycle k: register delay=k, pulse done for one cycle on the next clock, set delay_valid=1, clear busy, and return to IDLE.
- A path of N flops therefore reports delay=N.
- If the counter reaches MAX_DELAY without a match, that is the last compared cycle (so delay=MAX_DELAY is still reported).
- On the following clock with no match: pulse timeout, set delay to all-ones, keep delay_valid=0, clear busy, return to IDLE.
- Partial matches are never a match. For example, with DSIZE>1, a return value with only some bits set does not count.
- done and timeout are never high together.
- The counter is CSIZE wide and must not wrap, because it saturates through the timeout path.
- Reset during FLUSH, SEND or WAIT aborts the measurement. Dout returns to 0 immediately. The next start begins with a full FLUSH.
- If start arrives in the same cycle that done or timeout is asserted, it is ignored, because busy is still 1 in that cycle.

Decomposition:
- Package sync_delay_pkg holds:
  - the state enum (IDLE/FLUSH/SEND/WAIT);
  - the MARKER and IDLE data constants, as functions of DSIZE;
  - the clog2-based width helper.
- One shared up-counter sub-module, sync_delay_cnt, is used for both the FLUSH length and the WAIT count. It has clear, enable, and a terminal-count flag at MAX_DELAY.
- The FSM and output registers live in the top module.

Test Plan:
- Dout wired directly to Din_ret, start pulsed: after 64 FLUSH cycles plus SEND, done pulses, delay=0, delay_valid=1.
- 5-flop chain model between Dout and Din_ret: delay=5, with done exactly 5 cycles after SEND plus one registered cycle.
- RAM-based shift register DUT set for 10 cycles of latency, with DSIZE=4: delay=10, and a return of 4'b0111 injected mid-wait does not count as a match.
- Din_ret tied to 0: timeout pulses after MAX_DELAY+1 compare cycles, delay=all-ones, delay_valid=0, busy falls.
- start pulsed again in FLUSH and in WAIT: no effect; exactly one done; count is unchanged.
- Reset driven low in WAIT with a 20-flop path: Dout, busy and delay_valid are 0 immediately. After release, a new start measures delay=20, because the flush removed the stale marker.

Source files
------------

// File: rtl/sync_delay_pkg.sv
// Shared definitions for the delay-path latency measurement block.
package sync_delay_pkg;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_SEND  = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  // All-ones word of the given width. Callers cast it down to their data
  // width, so widths up to 64 bits are supported.
  function automatic logic [63:0] marker_word(input int width);
    if (width >= 64) return '1;
    return (64'd1 << width) - 64'd1;
  endfunction

  // Value driven into the path whenever no marker is being sent.
  function automatic logic [63:0] idle_word(input int width);
    return (width > 0) ? 64'd0 : 64'd0;
  endfunction

  // Counter width able to hold every value from 0 up to max_delay.
  function automatic int cnt_width(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

endpackage

// File: rtl/sync_delay_cnt.sv
// Saturating up-counter shared by the flush phase and the wait phase.
import sync_delay_pkg::*;

module sync_delay_cnt #(
  parameter int MAX_DELAY = 64,
  parameter int CSIZE     = cnt_width(MAX_DELAY)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             en,
  output logic [CSIZE-1:0] count,
  output logic             tc,
  output logic             pre_tc
);

  // tc marks the last measurable cycle; pre_tc ends a MAX_DELAY-long flush.
  assign tc     = (count == CSIZE'(MAX_DELAY));
  assign pre_tc = (count == CSIZE'(MAX_DELAY - 1));

  // Count up, holding at MAX_DELAY so the value can never wrap.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sync_delay_measure.sv
// Drives a marker into a delay path and reports how many cycles it takes
// to come back. The path is flushed with idle data first so stale markers
// from an earlier or aborted measurement cannot be mistaken for the new one.
import sync_delay_pkg::*;

module sync_delay_measure #(
  parameter int DSIZE     = 1,
  parameter int MAX_DELAY = 64,
  parameter int CSIZE     = cnt_width(MAX_DELAY)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  output logic [DSIZE-1:0] Dout,
  input  logic [DSIZE-1:0] Din_ret,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CSIZE-1:0] delay,
  output logic             delay_valid,
  output state_t           state
);

  localparam logic [DSIZE-1:0] MARKER    = DSIZE'(marker_word(DSIZE));
  localparam logic [DSIZE-1:0] IDLE_DATA = DSIZE'(idle_word(DSIZE));

  // Request handshake: start is a single-cycle request that is accepted only
  // in IDLE while busy is 0. busy stays high through the done/timeout pulse
  // cycle and drops on the clock after it, so a start in any cycle where
  // busy is 1 (including the result cycle) is dropped without side effects.

  state_t           state_nxt;
  logic             cnt_clr;
  logic             cnt_en;
  logic [CSIZE-1:0] count;
  logic             cnt_tc;
  logic             cnt_pre;
  logic             match;

  // Only a full all-ones return counts; partial matches are ignored.
  assign match = (Din_ret == MARKER);

  sync_delay_cnt #(
    .MAX_DELAY (MAX_DELAY),
    .CSIZE     (CSIZE)
  ) u_cnt (
    .clk    (clk),
    .Reset  (Reset),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .count  (count),
    .tc     (cnt_tc),
    .pre_tc (cnt_pre)
  );

  // Next-state and counter control.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !busy) begin
          state_nxt = ST_FLUSH;
          cnt_clr   = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Counts 0..MAX_DELAY-1, i.e. exactly MAX_DELAY flush cycles.
        if (cnt_pre) begin
          state_nxt = ST_SEND;
          cnt_clr   = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_SEND: begin
        // SEND is cycle 0; leaving it without a match puts the counter at 1.
        if (match) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT;
          cnt_en    = 1'b1;
        end
      end
      ST_WAIT: begin
        if (match || cnt_tc) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, stimulus and result registers.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state       <= ST_IDLE;
      Dout        <= IDLE_DATA;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      delay       <= '0;
      delay_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      done    <= 1'b0;
      timeout <= 1'b0;
      Dout    <= (state_nxt == ST_SEND) ? MARKER : IDLE_DATA;
      case (state)
        ST_IDLE: begin
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            busy        <= 1'b1;
            delay_valid <= 1'b0;
          end
        end
        ST_SEND, ST_WAIT: begin
          if (match) begin
            done        <= 1'b1;
            delay       <= count;
            delay_valid <= 1'b1;
          end else if ((state == ST_WAIT) && cnt_tc) begin
            timeout     <= 1'b1;
            delay       <= '1;
            delay_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_delay_measure.sv
// Directed bench for sync_delay_measure: a DSIZE=1 instance behind a
// selectable flop chain and a DSIZE=4 instance behind a circular-buffer
// (RAM style) 10-cycle shift register.
import sync_delay_pkg::*;

module tb_sync_delay_measure;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // ---------------- DSIZE=1 instance ----------------
  logic       start1;
  logic [0:0] dout1, ret1;
  logic       busy1, done1, tmo1, dv1;
  logic [6:0] delay1;
  state_t     st1;

  int          path_len  = 0;
  logic        path_zero = 1'b0;
  logic [31:0] sr1       = '0;

  always @(posedge clk) sr1 <= {sr1[30:0], dout1[0]};
  assign ret1[0] = path_zero ? 1'b0 : ((path_len == 0) ? dout1[0] : sr1[path_len-1]);

  sync_delay_measure #(.DSIZE(1), .MAX_DELAY(64)) dut1 (
    .clk(clk), .Reset(reset_n), .start(start1), .Dout(dout1), .Din_ret(ret1),
    .busy(busy1), .done(done1), .timeout(tmo1), .delay(delay1),
    .delay_valid(dv1), .state(st1)
  );

  // ---------------- DSIZE=4 instance ----------------
  logic       start4;
  logic [3:0] dout4, ret4;
  logic       busy4, done4, tmo4, dv4;
  logic [6:0] delay4;
  state_t     st4;

  logic [3:0] mem4 [16] = '{default: 4'h0};
  logic [3:0] wp4       = 4'h0;
  logic       inject4   = 1'b0;

  always @(posedge clk) begin
    mem4[wp4] <= dout4;
    wp4       <= wp4 + 4'd1;
  end
  assign ret4 = inject4 ? 4'b0111 : mem4[wp4 - 4'd10];

  sync_delay_measure #(.DSIZE(4), .MAX_DELAY(64)) dut4 (
    .clk(clk), .Reset(reset_n), .start(start4), .Dout(dout4), .Din_ret(ret4),
    .busy(busy4), .done(done4), .timeout(tmo4), .delay(delay4),
    .delay_valid(dv4), .state(st4)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Pulse start on dut1 and watch up to 200 cycles. Cycle i means "after the
  // i-th rising edge following the accepting edge". Extra start pulses are
  // driven at cycles ra and rb.
  task automatic run1(input int ra, input int rb, output int t_send, output int t_end);
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    t_send = -1;
    t_end  = -1;
    check("dut1_busy_after_start", {31'd0, busy1}, 32'd1);
    check("dut1_dv_cleared_on_start", {31'd0, dv1}, 32'd0);
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (t_send < 0 && dout1 === 1'b1) t_send = i;
      if (done1 || tmo1) begin
        t_end = i;
        break;
      end
      start1 = (i == ra) || (i == rb);
    end
    start1 = 1'b0;
  endtask

  task automatic run4(input int inj, output int t_send, output int t_end);
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    t_send = -1;
    t_end  = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (t_send < 0 && dout4 === 4'hf) t_send = i;
      if (done4 || tmo4) begin
        t_end = i;
        break;
      end
      inject4 = (i == inj);
    end
    inject4 = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int ts, te, extra;
    start1  = 1'b0;
    start4  = 1'b0;
    reset_n = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_timeout", {31'd0, tmo1}, 32'd0);
    check("rst_delay", {25'd0, delay1}, 32'd0);
    check("rst_dv", {31'd0, dv1}, 32'd0);
    check("rst_dout", {31'd0, dout1}, 32'd0);
    check("rst_state", {30'd0, st1}, {30'd0, ST_IDLE});
    check("rst_dout4", {28'd0, dout4}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Direct wire: SEND after 64 flush cycles, done on the next clock
    path_len = 0;
    run1(-1, -1, ts, te);
    check("wire_send_cycle", ts, 64);
    check("wire_done_cycle", te, 65);
    check("wire_done", {31'd0, done1}, 32'd1);
    check("wire_no_timeout", {31'd0, tmo1}, 32'd0);
    check("wire_delay", {25'd0, delay1}, 32'd0);
    check("wire_dv", {31'd0, dv1}, 32'd1);
    @(negedge clk);
    check("wire_done_pulse_ends", {31'd0, done1}, 32'd0);
    check("wire_busy_falls", {31'd0, busy1}, 32'd0);
    check("wire_delay_held", {25'd0, delay1}, 32'd0);
    check("wire_dv_held", {31'd0, dv1}, 32'd1);

    // 5-flop chain
    path_len = 5;
    repeat (2) @(negedge clk);
    run1(-1, -1, ts, te);
    check("chain5_done_cycle", te, 70);
    check("chain5_send_to_done", te - ts, 6);
    check("chain5_delay", {25'd0, delay1}, 32'd5);
    check("chain5_dv", {31'd0, dv1}, 32'd1);

    // Starts during FLUSH and WAIT are ignored, as is one in the done cycle
    path_len = 7;
    repeat (2) @(negedge clk);
    run1(10, 67, ts, te);
    check("restart_done_cycle", te, 72);
    check("restart_delay", {25'd0, delay1}, 32'd7);
    check("restart_busy_in_done_cycle", {31'd0, busy1}, 32'd1);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    extra = 0;
    for (int i = 0; i < 140; i++) begin
      if (done1 || busy1) extra++;
      @(negedge clk);
    end
    check("restart_no_second_run", extra, 0);
    check("restart_delay_unchanged", {25'd0, delay1}, 32'd7);

    // Path returning nothing: timeout after compares 0..64
    path_zero = 1'b1;
    run1(-1, -1, ts, te);
    check("tmo_cycle", te, 129);
    check("tmo_pulse", {31'd0, tmo1}, 32'd1);
    check("tmo_not_done", {31'd0, done1}, 32'd0);
    check("tmo_delay_ones", {25'd0, delay1}, 32'd127);
    check("tmo_dv", {31'd0, dv1}, 32'd0);
    @(negedge clk);
    check("tmo_busy_falls", {31'd0, busy1}, 32'd0);
    check("tmo_pulse_ends", {31'd0, tmo1}, 32'd0);

    // Reset in WAIT with a 20-flop path, then a clean re-measure
    path_zero = 1'b0;
    path_len  = 20;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (69) @(negedge clk);
    check("abort_in_wait", {30'd0, st1}, {30'd0, ST_WAIT});
    reset_n = 1'b0;
    #1;
    check("abort_dout", {31'd0, dout1}, 32'd0);
    check("abort_busy", {31'd0, busy1}, 32'd0);
    check("abort_dv", {31'd0, dv1}, 32'd0);
    check("abort_state", {30'd0, st1}, {30'd0, ST_IDLE});
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run1(-1, -1, ts, te);
    check("after_abort_done_cycle", te, 85);
    check("after_abort_delay", {25'd0, delay1}, 32'd20);
    check("after_abort_done", {31'd0, done1}, 32'd1);

    // DSIZE=4, RAM-style 10-cycle path, partial value 4'b0111 in WAIT cycle 4
    repeat (2) @(negedge clk);
    run4(68, ts, te);
    check("ram_send_cycle", ts, 64);
    check("ram_done_cycle", te, 75);
    check("ram_done", {31'd0, done4}, 32'd1);
    check("ram_delay", {25'd0, delay4}, 32'd10);
    check("ram_dv", {31'd0, dv4}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
